fp_normalizer: RTL
==================

FP_NORMALIZER -- requirements
Module: fp_normalizer

Interface
REQ-001 SHALL have parameter MANT_W, default 25, the mantissa width including carry bit MANT_W-1 and hidden bit MANT_W-2.
REQ-002 SHALL have parameter EXP_W, default 8, the biased exponent width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request that loads mant_in/exp_in; honoured only in IDLE.
REQ-006 SHALL have port mant_in  input  MANT_W  raw mantissa from the add/sub stage.
REQ-007 SHALL have port exp_in  input  EXP_W  raw exponent paired with mant_in.
REQ-008 SHALL have port busy  output  1  high in SHIFT and DONE states.
REQ-009 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-010 SHALL have port mant_out  output  MANT_W  normalized mantissa.
REQ-011 SHALL have port exp_out  output  EXP_W  adjusted exponent.
REQ-012 SHALL have port shift_ctl  output  2  per-cycle shift command: 0 left, 1 hold, 2 right.
REQ-013 SHALL have ports zero, overflow, underflow, sticky  output  1 each  status flags, valid with done.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-015 IDLE + start SHALL capture mant_in/exp_in into mant_r/exp_r, clear all flags, and go to SHIFT.
REQ-016 In SHIFT, each cycle SHALL apply the first matching rule: mant_r==0 -> zero=1, exp_r=0, go DONE; bit MANT_W-1 set -> shift right one, exp_r+1, stay; bit MANT_W-2 set -> go DONE; exp_r==0 -> underflow=1, go DONE; otherwise -> shift left one, exp_r-1, stay.
REQ-017 A right shift producing exp_r == all ones SHALL set overflow=1; normalization continues.
REQ-018 shift_ctl SHALL equal the command applied that cycle in SHIFT, and 1 (hold) in IDLE and DONE.
REQ-019 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-020 Latency SHALL be 2 + N cycles from the start cycle to done, where N is the number of shifts performed.
REQ-021 start SHALL be ignored in SHIFT and DONE, with no effect on state or registers.
REQ-022 mant_out/exp_out/flags SHALL be driven from mant_r/exp_r/flag registers and hold until the next accepted start.
REQ-023 Exponent arithmetic SHALL be EXP_W-bit unsigned; REQ-016 ordering SHALL guarantee that exp_r never wraps.

Reset
REQ-024 reset SHALL force IDLE, with mant_out=0, exp_out=0, all flags=0, done=0, busy=0, and shift_ctl=1.
REQ-025 reset SHALL take priority over start and abort any in-flight operation without asserting done.

Configuration
REQ-026 With NORM_STICKY_EN defined, every right shift SHALL OR the bit shifted out of bit 0 into sticky.
REQ-027 Without NORM_STICKY_EN, sticky SHALL be tied to 0 and no sticky register SHALL exist.

Structure
REQ-028 Package norm_pkg SHALL hold the state enum and the shift_ctl constants SH_LEFT=2'd0, SH_HOLD=2'd1, and SH_RIGHT=2'd2.
REQ-029 A combinational sub-module norm_step (MANT_W-bit one-bit left/right/hold shift driven by shift_ctl) SHALL perform the mantissa shift.

Verification
REQ-030 mant_in=0x0800000, exp_in=0x80 -> done at cycle 2, mant_out=0x0800000, exp_out=0x80, all flags 0.
REQ-031 mant_in=0x1800001, exp_in=0x80 -> done at cycle 3, mant_out=0x0C00000, exp_out=0x81, sticky=1 with NORM_STICKY_EN and 0 without.
REQ-032 mant_in=0x0000001, exp_in=0x80 -> 23 left shifts, done at cycle 25, mant_out=0x0800000, exp_out=0x69.
REQ-033 mant_in=0, exp_in=0x45 -> done at cycle 2, zero=1, mant_out=0, exp_out=0; mant_in=0x0000100, exp_in=0x05 -> done at cycle 7, underflow=1, mant_out=0x0002000, exp_out=0.
REQ-034 mant_in=0x1000000, exp_in=0xFE -> done at cycle 3, overflow=1, mant_out=0x0800000, exp_out=0xFF.
REQ-035 Reset asserted at cycle 5 of the REQ-032 case, plus start pulsed mid-SHIFT in a separate run -> reset returns IDLE with no done pulse; the mid-SHIFT start leaves results unchanged.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared types and shift-command encodings for the floating-point normalizer.
package norm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] SH_LEFT  = 2'd0;
  localparam logic [1:0] SH_HOLD  = 2'd1;
  localparam logic [1:0] SH_RIGHT = 2'd2;

endpackage

// File: rtl/norm_step.sv
// One-bit mantissa shifter: left, right or hold as selected by shift_ctl.
module norm_step
  import norm_pkg::*;
#(
  parameter int MANT_W = 25
) (
  input  logic [1:0]        shift_ctl,
  input  logic [MANT_W-1:0] mant_i,
  output logic [MANT_W-1:0] mant_o
);

  // Shift select
  always_comb begin
    mant_o = mant_i;
    case (shift_ctl)
      SH_LEFT:  mant_o = {mant_i[MANT_W-2:0], 1'b0};
      SH_RIGHT: mant_o = {1'b0, mant_i[MANT_W-1:1]};
      SH_HOLD:  mant_o = mant_i;
      default:  mant_o = mant_i;
    endcase
  end

endmodule

// File: rtl/fp_normalizer.sv
// Iterative mantissa normalizer (IDLE/SHIFT/DONE), one bit shift per cycle.
// Optional feature: define NORM_STICKY_EN to accumulate right-shifted-out bits in sticky.
module fp_normalizer
  import norm_pkg::*;
#(
  parameter int MANT_W = 25,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MANT_W-1:0] mant_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              busy,
  output logic              done,
  output logic [MANT_W-1:0] mant_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [1:0]        shift_ctl,
  output logic              zero,
  output logic              overflow,
  output logic              underflow,
  output logic              sticky
);

  localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};

  state_e            state_q, state_d;
  logic [MANT_W-1:0] mant_q, mant_d, step_mant;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [1:0]        shift_ctl_q, shift_ctl_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              zero_q, zero_d, ovf_q, ovf_d, udf_q, udf_d;

  // The command is precomputed from next-cycle values so shift_ctl is a flop
  // yet still reflects the shift applied during that same cycle.
  function automatic logic [1:0] pick_cmd(input logic [MANT_W-1:0] m,
                                          input logic [EXP_W-1:0]  e);
    if (m == '0)              return SH_HOLD;
    else if (m[MANT_W-1])     return SH_RIGHT;
    else if (m[MANT_W-2])     return SH_HOLD;
    else if (e == '0)         return SH_HOLD;
    else                      return SH_LEFT;
  endfunction

  norm_step #(.MANT_W(MANT_W)) u_step (
    .shift_ctl (shift_ctl_q),
    .mant_i    (mant_q),
    .mant_o    (step_mant)
  );

`ifdef NORM_STICKY_EN
  logic sticky_q, sticky_d;
`endif

  always_comb begin
    state_d     = state_q;
    mant_d      = mant_q;
    exp_d       = exp_q;
    shift_ctl_d = SH_HOLD;
    busy_d      = busy_q;
    done_d      = 1'b0;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
`ifdef NORM_STICKY_EN
    sticky_d    = sticky_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_SHIFT;
          mant_d      = mant_in;
          exp_d       = exp_in;
          busy_d      = 1'b1;
          zero_d      = 1'b0;
          ovf_d       = 1'b0;
          udf_d       = 1'b0;
`ifdef NORM_STICKY_EN
          sticky_d    = 1'b0;
`endif
          shift_ctl_d = pick_cmd(mant_in, exp_in);
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        case (shift_ctl_q)
          SH_RIGHT: begin
            mant_d = step_mant;
            exp_d  = exp_q + EXP_ONE;
            if (exp_d == EXP_ONES) begin
              ovf_d = 1'b1;
            end else begin
              ovf_d = ovf_q;
            end
`ifdef NORM_STICKY_EN
            sticky_d = sticky_q | mant_q[0];
`endif
            shift_ctl_d = pick_cmd(mant_d, exp_d);
          end
          SH_LEFT: begin
            mant_d      = step_mant;
            exp_d       = exp_q - EXP_ONE;
            shift_ctl_d = pick_cmd(mant_d, exp_d);
          end
          default: begin
            // Hold is only chosen for zero, already-normal, or exhausted exponent.
            state_d = ST_DONE;
            done_d  = 1'b1;
            if (mant_q == '0) begin
              zero_d = 1'b1;
              exp_d  = '0;
            end else if (!mant_q[MANT_W-2]) begin
              udf_d = 1'b1;
            end else begin
              udf_d = udf_q;
            end
          end
        endcase
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mant_q      <= '0;
      exp_q       <= '0;
      shift_ctl_q <= SH_HOLD;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
`ifdef NORM_STICKY_EN
      sticky_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      exp_q       <= exp_d;
      shift_ctl_q <= shift_ctl_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
`ifdef NORM_STICKY_EN
      sticky_q    <= sticky_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mant_out  = mant_q;
  assign exp_out   = exp_q;
  assign shift_ctl = shift_ctl_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
`ifdef NORM_STICKY_EN
  assign sticky    = sticky_q;
`else
  assign sticky    = 1'b0;
`endif

endmodule
